// File: rtl/maze_pkg.sv
// Shared maze-game definitions: keypad geometry, key codes for the movement
// logic, and the lowest-pressed-key helper.
package maze_pkg;

  localparam int unsigned KP_COLS   = 5;
  localparam int unsigned KP_ROWS   = 4;
  localparam int unsigned KP_KEYS   = KP_COLS * KP_ROWS;
  localparam int unsigned KP_CODE_W = 5;

  typedef logic [KP_CODE_W-1:0] key_code_t;
  typedef logic [KP_KEYS-1:0]   key_map_t;

  // Key code = col*4 + row
  localparam key_code_t KEY_UP    = 5'd1;
  localparam key_code_t KEY_DOWN  = 5'd9;
  localparam key_code_t KEY_LEFT  = 5'd4;
  localparam key_code_t KEY_RIGHT = 5'd12;
  localparam key_code_t KEY_START = 5'd16;

  // Index of the lowest set bit; 0 when the map is empty.
  function automatic key_code_t kp_lowest(input key_map_t v);
    key_code_t idx;
    idx = '0;
    for (int i = KP_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = KP_CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; resets to RESET_VAL.
module sync_2ff #(
  parameter int unsigned       WIDTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/maze_keypad_scan.sv
// 5x4 keypad scanner: column walk, frame debounce, lowest-new-press event
// register with valid/ack handshake and sticky overrun.
module maze_keypad_scan
  import maze_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEBOUNCE_N = 4
) (
  input  logic               clk,
  input  logic               clr,
  output logic [KP_COLS-1:0] btn_x,
  input  logic [KP_ROWS-1:0] btn_y,
  output logic               key_valid,
  output key_code_t          key_code,
  input  logic               key_ack,
  output logic               key_down,
  output logic               overrun
);

  localparam int unsigned DCNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned MATCH_W = (DEBOUNCE_N > 1) ? $clog2(DEBOUNCE_N) : 1;
  localparam int unsigned COL_W   = 3;

  localparam logic [DCNT_W-1:0]  DCNT_LAST = DCNT_W'(SCAN_DIV - 1);
  localparam logic [MATCH_W-1:0] MATCH_SAT = MATCH_W'(DEBOUNCE_N - 1);
  localparam logic [COL_W-1:0]   COL_LAST  = COL_W'(KP_COLS - 1);

  logic [KP_ROWS-1:0] w_rows_n;
  logic               w_sample;
  logic               w_frame_end;
  logic [COL_W-1:0]   w_col_next;
  key_map_t           w_raw_next;
  logic               w_same;
  logic [MATCH_W-1:0] w_match_next;
  key_map_t           w_stable_next;
  key_map_t           w_newp;
  logic               w_event;
  logic               w_load;
  logic               w_ack;

  logic [COL_W-1:0]   r_col;
  logic [DCNT_W-1:0]  r_dcnt;
  key_map_t           r_raw;
  key_map_t           r_last;
  logic [MATCH_W-1:0] r_match;
  key_map_t           r_stable;
  logic [KP_COLS-1:0] r_btn_x;
  logic               r_key_valid;
  key_code_t          r_key_code;
  logic               r_key_down;
  logic               r_overrun;

  sync_2ff #(
    .WIDTH     (KP_ROWS),
    .RESET_VAL ({KP_ROWS{1'b1}})
  ) u_sync (
    .clk (clk),
    .clr (clr),
    .i_d (btn_y),
    .o_q (w_rows_n)
  );

  // Scan, debounce and press-detect next-state
  always_comb begin
    w_sample    = (r_dcnt == DCNT_LAST);
    w_frame_end = w_sample && (r_col == COL_LAST);
    w_col_next  = (r_col == COL_LAST) ? '0 : r_col + COL_W'(1);

    w_raw_next = r_raw;
    if (w_sample) begin
      for (int c = 0; c < int'(KP_COLS); c++) begin
        if (r_col == COL_W'(c)) w_raw_next[c*KP_ROWS +: KP_ROWS] = ~w_rows_n;
      end
    end

    w_same       = (w_raw_next == r_last);
    w_match_next = '0;
    if (w_same) begin
      w_match_next = (r_match == MATCH_SAT) ? r_match : r_match + MATCH_W'(1);
    end

    // Stable only moves once the frame has repeated DEBOUNCE_N times
    w_stable_next = r_stable;
    if (w_frame_end && (w_match_next == MATCH_SAT)) w_stable_next = w_raw_next;

    w_newp  = w_stable_next & ~r_stable;
    w_event = w_frame_end && (|w_newp);
    w_load  = w_event && (!r_key_valid || key_ack);
    w_ack   = key_ack && r_key_valid;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_col       <= '0;
      r_dcnt      <= '0;
      r_raw       <= '0;
      r_last      <= '0;
      r_match     <= '0;
      r_stable    <= '0;
      r_btn_x     <= ~KP_COLS'(1);
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
      r_key_down  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_sample) begin
        r_dcnt  <= '0;
        r_raw   <= w_raw_next;
        r_col   <= w_col_next;
        r_btn_x <= ~(KP_COLS'(1) << w_col_next);
      end else begin
        r_dcnt <= r_dcnt + DCNT_W'(1);
      end

      if (w_frame_end) begin
        r_last     <= w_raw_next;
        r_match    <= w_match_next;
        r_stable   <= w_stable_next;
        r_key_down <= |w_stable_next;
      end

      // An ack in the same cycle as a new event makes room for it
      if (w_load) begin
        r_key_valid <= 1'b1;
        r_key_code  <= kp_lowest(w_newp);
      end else if (w_ack) begin
        r_key_valid <= 1'b0;
      end

      if (w_event && !w_load) r_overrun <= 1'b1;
      else if (w_ack)         r_overrun <= 1'b0;
    end
  end

  assign btn_x     = r_btn_x;
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign key_down  = r_key_down;
  assign overrun   = r_overrun;

endmodule

// File: doc/maze_keypad_scan.md
# maze_keypad_scan

Keypad front end for the maze game. It scans the 5×4 button matrix by driving one column low at a time on `btn_x` and reading the active-low rows on `btn_y`. It debounces whole scan frames and hands one key-press event at a time to the game logic through a valid/ack register. It sits directly upstream of the maze top-level movement logic, which today takes the raw `BTN_X`/`BTN_Y` lines.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clock cycles each column is driven. At 100 MHz this is 0.5 ms. Minimum legal value is 4.
- `DEBOUNCE_N`, default 4: number of consecutive identical frames required before the debounced key state updates. Minimum legal value is 1.

Ports:
- `clk` in 1: single system clock.
- `clr` in 1: synchronous, active-high reset.
- `btn_x` out 5: column drive, active-low. Exactly one bit is 0 at any time.
- `btn_y` in 4: row sense, active-low, asynchronous, pulled high.
- `key_valid` out 1: a key-press event is pending.
- `key_code` out 5: code of the pending key, `col*4 + row`, range 0..19.
- `key_ack` in 1: consumer pulse that clears the pending event.
- `key_down` out 1: at least one debounced key is held.
- `overrun` out 1: sticky flag, set when an event was dropped.

## Operation
- Synchronisation: `btn_y` passes through 2 flops. All logic uses only the synchronised value.
- Column counter `col` (0..4) and dwell counter `dcnt` (0..SCAN_DIV-1):
  - `btn_x = ~(5'b1 << col)`.
  - When `dcnt == SCAN_DIV-1`: write the inverted synchronised rows into raw-frame bits `[col*4 +: 4]`, then advance `col`, wrapping 4→0.
- Frame end is the sample cycle with `col == 4`. The completed raw frame `R` (20 bits, bit 1 = pressed) is then debounced:
  - If `R == last_R`, increment the match count, saturating at DEBOUNCE_N-1.
  - Otherwise load `last_R <= R` and clear the match count.
  - `stable <= R` in the frame-end cycle where `R` has been seen DEBOUNCE_N consecutive frames, i.e. match count reaches, or already is, DEBOUNCE_N-1.
- Press detect: `newp = stable_next & ~stable`.
  - If `newp` is nonzero, the event is the lowest set index. Other new presses in the same update are discarded without flagging overrun.
  - Releases produce no event.
- Event register:
  - If `key_valid == 0` or `key_ack == 1`, load the event: `key_valid <= 1`, `key_code <= index`.
  - Otherwise drop the event and set `overrun`.
  - `key_ack` with no new event clears `key_valid`. `key_code` holds its last value.
  - Simultaneous ack and new event: the new event is loaded and `key_valid` stays 1.
  - `key_ack` while `key_valid == 0` is ignored.
- `overrun` clears only on `clr` or on a `key_ack` cycle that loads no dropped event.
- `key_down = |stable`, registered.
- `clr` mid-scan or mid-event returns everything to reset state on the next edge. A pending event is lost.

## Timing
- Reset values:
  - Outputs: `btn_x = 5'b11110`, `key_valid = 0`, `key_code = 0`, `key_down = 0`, `overrun = 0`.
  - Internal: `col`, `dcnt`, raw frame, `last_R`, `stable` and match count are all 0.
- Frame period is 5·SCAN_DIV cycles. Each column is sampled SCAN_DIV-1 cycles after its drive edge; the synchroniser needs SCAN_DIV ≥ 4.
- `key_valid`, `key_code`, `key_down` and `overrun` update on the edge after the frame-end sample cycle.
- Latency from a clean, stable press to `key_valid`: the first frame that fully contains the press, plus DEBOUNCE_N-1 further frames, plus 1 cycle.
- A press shorter than DEBOUNCE_N frames produces no event.

## Structure
- Shared package `maze_pkg` holds:
  - `KP_COLS = 5`, `KP_ROWS = 4`.
  - Key-code constants used by the movement logic: `KEY_UP`, `KEY_DOWN`, `KEY_LEFT`, `KEY_RIGHT`, `KEY_START`.
- One sub-module, `sync_2ff`, the 4-bit 2-flop synchroniser, reused elsewhere for other asynchronous inputs.
- Everything else lives in a single module.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_N=2, frame period = 20 cycles.
- Reset: hold `clr` for 3 cycles → `btn_x = 11110`, all outputs 0. After release, `btn_x` walks 11110 → 11101 → … → 01111 every 4 cycles and wraps back to 11110.
- Single press: the row model pulls `btn_y[2]` low whenever `btn_x[3] == 0`, held for 3 frames → one `key_valid` with `key_code = 14`, and `key_down = 1`. Hold `key_ack` low → `key_valid` stays 1. Pulse `key_ack` → `key_valid = 0`. Release → `key_down` returns to 0 and no event is produced.
- Bounce: row 0 / column 1 asserted for 1 frame, released for 1 frame, repeated 4 times → no event, `key_down` never 1.
- Two simultaneous presses, codes 5 and 17, stable together → exactly one event with `key_code = 5`, and `overrun = 0`.
- Overrun: press code 3 and do not ack. Release it, then press code 9 → `key_valid` stays 1, `key_code = 3`, `overrun = 1`. Ack → `key_valid = 0`, `overrun = 0`.
- `clr` asserted mid-frame while an event is pending → on the next edge `key_valid = 0`, `key_code = 0`, `btn_x = 11110`. The still-held key re-debounces and produces a fresh event 2 frames later.
